dm_master: RTL and testbench

//  Initiator side of the word-addressed data memory interface (Read, 4-bit byte-lane

---
 rtl/dm_master.sv | 194 +++++++++++++++++++
 tb/tb_dm_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_master.sv
// Data-memory initiator: turns one byte/half/word load or store into one word bus access.
// Latency: accept at E0, response pulse after E2 with zero-wait memory; each wait cycle adds one.
// Backpressure: Req_Ready is high only in IDLE; the requester holds Req_Valid until accepted.
//
// Ports:
//   clock, reset (async, active low)
//   Req_*      : pipeline request (valid/ready handshake, size, sign, byte address, data)
//   Rsp_*      : one-cycle response pulse with extended load data and error flags
//   DataMem_*  : word-addressed memory bus with big-endian byte-lane write enables
module dm_master #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        Req_Write,
    input  logic [1:0]  Req_Size,
    input  logic        Req_Signed,
    input  logic [31:0] Req_Addr,
    input  logic [31:0] Req_WData,
    output logic        Rsp_Valid,
    output logic [31:0] Rsp_RData,
    output logic        Rsp_AddrErr,
    output logic        Rsp_BusErr,
    output logic        DataMem_Read,
    output logic [3:0]  DataMem_Write,
    output logic [29:0] DataMem_Address,
    output logic [31:0] DataMem_Out,
    input  logic [31:0] DataMem_In,
    input  logic        DataMem_Ready
);

    localparam int WDW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        rd_q, rd_d;
    logic [3:0]  wr_q, wr_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] out_q, out_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic        rsp_vld_q, rsp_vld_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_aerr_q, rsp_aerr_d;
    logic        rsp_berr_q, rsp_berr_d;

    logic        req_illegal;
    logic [3:0]  req_lanes;
    logic [31:0] req_out;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        req_illegal = (Req_Size == 2'b11)
                   || (Req_Size == 2'b01 && Req_Addr[0])
                   || (Req_Size == 2'b10 && Req_Addr[1:0] != 2'b00);
        // Byte offset 0 lives in lane 3 (bits 31:24): big-endian layout.
        case (Req_Size)
            2'b00: begin
                req_lanes = 4'b1000 >> Req_Addr[1:0];
                req_out   = {4{Req_WData[7:0]}};
            end
            2'b01: begin
                req_lanes = Req_Addr[1] ? 4'b0011 : 4'b1100;
                req_out   = {2{Req_WData[15:0]}};
            end
            default: begin
                req_lanes = 4'b1111;
                req_out   = Req_WData;
            end
        endcase
    end

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = DataMem_In[31:24];
            2'd1:    ld_byte = DataMem_In[23:16];
            2'd2:    ld_byte = DataMem_In[15:8];
            default: ld_byte = DataMem_In[7:0];
        endcase
        ld_half = off_q[1] ? DataMem_In[15:0] : DataMem_In[31:16];
        case (size_q)
            2'b00:   ld_ext = {{24{sgn_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{sgn_q & ld_half[15]}}, ld_half};
            default: ld_ext = DataMem_In;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        out_d       = out_q;
        off_d       = off_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        wd_d        = wd_q;
        rsp_vld_d   = 1'b0;
        rsp_rdata_d = 32'd0;
        rsp_aerr_d  = 1'b0;
        rsp_berr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Req_Valid) begin
                    if (req_illegal) begin
                        state_d    = RECOVER;
                        rsp_vld_d  = 1'b1;
                        rsp_aerr_d = 1'b1;
                    end else begin
                        state_d = ACCESS;
                        wd_d    = '0;
                        off_d   = Req_Addr[1:0];
                        size_d  = Req_Size;
                        sgn_d   = Req_Signed;
                        addr_d  = Req_Addr[31:2];
                        rd_d    = ~Req_Write;
                        wr_d    = Req_Write ? req_lanes : 4'b0000;
                        out_d   = Req_Write ? req_out : 32'd0;
                    end
                end
            end
            ACCESS: begin
                if (DataMem_Ready || wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = RECOVER;
                    rd_d        = 1'b0;
                    wr_d        = 4'b0000;
                    addr_d      = 30'd0;
                    out_d       = 32'd0;
                    rsp_vld_d   = 1'b1;
                    rsp_berr_d  = ~DataMem_Ready;
                    rsp_rdata_d = (DataMem_Ready && rd_q) ? ld_ext : 32'd0;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            // The memory's registered ack is still high here; ignore it.
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rd_q        <= 1'b0;
            wr_q        <= 4'b0000;
            addr_q      <= 30'd0;
            out_q       <= 32'd0;
            off_q       <= 2'd0;
            size_q      <= 2'd0;
            sgn_q       <= 1'b0;
            wd_q        <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_aerr_q  <= 1'b0;
            rsp_berr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            out_q       <= out_d;
            off_q       <= off_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            wd_q        <= wd_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_aerr_q  <= rsp_aerr_d;
            rsp_berr_q  <= rsp_berr_d;
        end
    end

    assign Req_Ready       = (state_q == IDLE);
    assign Rsp_Valid       = rsp_vld_q;
    assign Rsp_RData       = rsp_rdata_q;
    assign Rsp_AddrErr     = rsp_aerr_q;
    assign Rsp_BusErr      = rsp_berr_q;
    assign DataMem_Read    = rd_q;
    assign DataMem_Write   = wr_q;
    assign DataMem_Address = addr_q;
    assign DataMem_Out     = out_q;

endmodule

// File: tb/tb_dm_master.sv
module tb_dm_master;

    logic        clock;
    logic        reset;
    logic        Req_Valid;
    logic        Req_Ready;
    logic        Req_Write;
    logic [1:0]  Req_Size;
    logic        Req_Signed;
    logic [31:0] Req_Addr;
    logic [31:0] Req_WData;
    logic        Rsp_Valid;
    logic [31:0] Rsp_RData;
    logic        Rsp_AddrErr;
    logic        Rsp_BusErr;
    logic        DataMem_Read;
    logic [3:0]  DataMem_Write;
    logic [29:0] DataMem_Address;
    logic [31:0] DataMem_Out;
    logic [31:0] DataMem_In;
    logic        DataMem_Ready;

    int checks = 0;
    int failures = 0;

    dm_master #(.TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Write(Req_Write),
        .Req_Size(Req_Size), .Req_Signed(Req_Signed), .Req_Addr(Req_Addr),
        .Req_WData(Req_WData), .Rsp_Valid(Rsp_Valid), .Rsp_RData(Rsp_RData),
        .Rsp_AddrErr(Rsp_AddrErr), .Rsp_BusErr(Rsp_BusErr),
        .DataMem_Read(DataMem_Read), .DataMem_Write(DataMem_Write),
        .DataMem_Address(DataMem_Address), .DataMem_Out(DataMem_Out),
        .DataMem_In(DataMem_In), .DataMem_Ready(DataMem_Ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference memory: plain byte array, byte address = index (low 8 bits).
    logic [7:0] ref_mem [0:255];

    // Bus-side memory with registered ack and programmable wait cycles.
    logic [31:0] mem_word [0:63];
    logic        mem_rdy_q;
    logic [31:0] mem_rd_q;
    int          mem_cnt;
    int          wait_n;
    int          rdy_mode;   // 0 = memory model, 1 = forced low, 2 = forced high
    logic        init_req;

    assign DataMem_In    = mem_rd_q;
    assign DataMem_Ready = (rdy_mode == 0) ? mem_rdy_q : (rdy_mode == 2);

    always @(posedge clock) begin
        logic strobe;
        logic [31:0] w;
        strobe = DataMem_Read | (|DataMem_Write);
        if (init_req) begin
            for (int i = 0; i < 64; i++)
                mem_word[i] <= {ref_mem[4*i], ref_mem[4*i+1], ref_mem[4*i+2], ref_mem[4*i+3]};
        end else if (strobe) begin
            w = mem_word[DataMem_Address[5:0]];
            for (int l = 0; l < 4; l++)
                if (DataMem_Write[l]) w[8*l +: 8] = DataMem_Out[8*l +: 8];
            mem_word[DataMem_Address[5:0]] <= w;
            mem_rd_q <= mem_word[DataMem_Address[5:0]];
        end
        mem_rdy_q <= strobe && (mem_cnt >= wait_n);
        mem_cnt   <= strobe ? mem_cnt + 1 : 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request end to end, with all expectations derived from byte-level rules.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input int waitn);
        logic        illegal;
        logic [1:0]  off;
        logic [7:0]  ba;
        logic [3:0]  exp_lanes;
        logic [31:0] exp_out;
        logic [31:0] exp_rd;
        logic [7:0]  b;
        logic [15:0] h;
        int          n;
        off = a[1:0];
        ba  = a[7:0];
        illegal = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && off != 2'd0);
        exp_lanes = 4'h0;
        exp_out = 32'd0;
        exp_rd = 32'd0;
        case (sz)
            2'd0: begin
                exp_lanes = 4'b0001 << (3 - off);
                exp_out = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
                b = ref_mem[ba];
                exp_rd = sg ? {{24{b[7]}}, b} : {24'd0, b};
            end
            2'd1: begin
                exp_lanes = 4'b0011 << (2 - off);
                exp_out = {wd[15:0], wd[15:0]};
                h = {ref_mem[ba], ref_mem[ba + 8'd1]};
                exp_rd = sg ? {{16{h[15]}}, h} : {16'd0, h};
            end
            default: begin
                exp_lanes = 4'hF;
                exp_out = wd;
                exp_rd = {ref_mem[ba], ref_mem[ba + 8'd1], ref_mem[ba + 8'd2], ref_mem[ba + 8'd3]};
            end
        endcase
        if (w) exp_rd = 32'd0;

        @(negedge clock);
        chk("req_ready_idle", {31'd0, Req_Ready}, 32'd1);
        wait_n = waitn;
        Req_Valid = 1'b1; Req_Write = w; Req_Size = sz; Req_Signed = sg;
        Req_Addr = a; Req_WData = wd;
        @(posedge clock); #1;
        Req_Valid = 1'b0;
        if (illegal) begin
            chk("aerr_rsp_valid", {31'd0, Rsp_Valid}, 32'd1);
            chk("aerr_flag", {31'd0, Rsp_AddrErr}, 32'd1);
            chk("aerr_buserr", {31'd0, Rsp_BusErr}, 32'd0);
            chk("aerr_rdata", Rsp_RData, 32'd0);
            chk("aerr_no_read", {31'd0, DataMem_Read}, 32'd0);
            chk("aerr_no_write", {28'd0, DataMem_Write}, 32'd0);
        end else begin
            chk("bus_read", {31'd0, DataMem_Read}, {31'd0, ~w});
            chk("bus_write", {28'd0, DataMem_Write}, w ? {28'd0, exp_lanes} : 32'd0);
            chk("bus_addr", {2'd0, DataMem_Address}, {2'd0, a[31:2]});
            chk("bus_out", DataMem_Out, w ? exp_out : 32'd0);
            n = 0;
            do begin
                @(posedge clock); #1;
                n++;
            end while (!Rsp_Valid && n < 40);
            chk("rsp_latency", n, 2 + waitn);
            chk("rsp_rdata", Rsp_RData, exp_rd);
            chk("rsp_errs", {30'd0, Rsp_AddrErr, Rsp_BusErr}, 32'd0);
            chk("strobes_dropped", {27'd0, DataMem_Read, DataMem_Write}, 32'd0);
            if (w) begin
                case (sz)
                    2'd0: ref_mem[ba] = wd[7:0];
                    2'd1: begin ref_mem[ba] = wd[15:8]; ref_mem[ba + 8'd1] = wd[7:0]; end
                    default: begin
                        ref_mem[ba] = wd[31:24]; ref_mem[ba + 8'd1] = wd[23:16];
                        ref_mem[ba + 8'd2] = wd[15:8]; ref_mem[ba + 8'd3] = wd[7:0];
                    end
                endcase
            end
        end
        @(posedge clock); #1;
        chk("rsp_one_pulse", {31'd0, Rsp_Valid}, 32'd0);
        chk("ready_after_recover", {31'd0, Req_Ready}, 32'd1);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int n;
        reset = 1'b0; Req_Valid = 1'b0; Req_Write = 1'b0; Req_Size = 2'd0;
        Req_Signed = 1'b0; Req_Addr = 32'd0; Req_WData = 32'd0;
        wait_n = 0; rdy_mode = 0; init_req = 1'b1; mem_cnt = 0;
        mem_rdy_q = 1'b0; mem_rd_q = 32'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_req_ready", {31'd0, Req_Ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, Rsp_Valid}, 32'd0);
        chk("rst_bus", {27'd0, DataMem_Read, DataMem_Write}, 32'd0);
        chk("rst_addr", {2'd0, DataMem_Address}, 32'd0);
        chk("rst_rdata", Rsp_RData, 32'd0);
        @(negedge clock);
        init_req = 1'b0;
        reset = 1'b1;

        // Directed sequence
        do_req(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'd0, 0);
        do_req(1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'h0000_00A5, 0);
        do_req(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'd0, 0);
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'd0, 1);
        do_req(1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'h0000_8001, 0);
        do_req(1'b0, 2'd1, 1'b1, 32'h0000_0022, 32'd0, 2);
        do_req(1'b0, 2'd1, 1'b0, 32'h0000_0020, 32'd0, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0011, 32'd0, 0);
        do_req(1'b0, 2'd1, 1'b1, 32'h0000_0013, 32'd0, 0);
        do_req(1'b1, 2'd3, 1'b0, 32'h0000_0014, 32'h1234_5678, 0);

        // Randomized requests
        for (int i = 0; i < 60; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 4) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
                if (sz == 2'd3) sz = 2'd2;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 3));
        end

        // Watchdog: memory never answers
        rdy_mode = 1;
        @(negedge clock);
        Req_Valid = 1'b1; Req_Write = 1'b0; Req_Size = 2'd2; Req_Addr = 32'h0000_0040;
        @(posedge clock); #1;
        Req_Valid = 1'b0;
        n = 0;
        do begin
            chk("to_read_held", {31'd0, DataMem_Read}, 32'd1);
            @(posedge clock); #1;
            n++;
        end while (!Rsp_Valid && n < 40);
        chk("to_access_cycles", n, 8);
        chk("to_buserr", {31'd0, Rsp_BusErr}, 32'd1);
        chk("to_addrerr", {31'd0, Rsp_AddrErr}, 32'd0);
        chk("to_rdata", Rsp_RData, 32'd0);
        chk("to_strobes_drop", {27'd0, DataMem_Read, DataMem_Write}, 32'd0);
        rdy_mode = 2;
        @(posedge clock); #1;
        chk("stale_ready_no_rsp", {31'd0, Rsp_Valid}, 32'd0);
        chk("stale_ready_idle", {31'd0, Req_Ready}, 32'd1);
        rdy_mode = 0;
        @(posedge clock); #1;
        chk("stale_ready_no_accept", {31'd0, Rsp_Valid}, 32'd0);

        // Asynchronous reset in the middle of an access
        @(negedge clock);
        wait_n = 3;
        Req_Valid = 1'b1; Req_Write = 1'b0; Req_Size = 2'd2; Req_Addr = 32'h0000_0010;
        @(posedge clock); #1;
        Req_Valid = 1'b0;
        chk("mid_read_active", {31'd0, DataMem_Read}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_bus", {27'd0, DataMem_Read, DataMem_Write}, 32'd0);
        chk("arst_addr", {2'd0, DataMem_Address}, 32'd0);
        chk("arst_rsp", {31'd0, Rsp_Valid}, 32'd0);
        chk("arst_ready", {31'd0, Req_Ready}, 32'd1);
        repeat (3) begin
            @(posedge clock); #1;
            chk("arst_no_rsp", {31'd0, Rsp_Valid}, 32'd0);
        end
        @(negedge clock);
        reset = 1'b1;
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'd0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
